fifo_wr_sched: RTL and testbench
================================

FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall be the width of one data beat.
REQ-002 Parameter NUM_REQ, default 4, shall be the number of requesters; legal range 2..8.
REQ-003 Parameter ID_WIDTH, default 2, shall be the grant_id width and shall satisfy 2**ID_WIDTH >= NUM_REQ.
REQ-004 clk  input  1  single clock; all state shall update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  per-requester beat; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  per-requester last beat of packet.
REQ-009 req_ready  output  NUM_REQ  per-requester beat accepted this cycle when also valid.
REQ-010 fifo_full  input  1  FULL status from the FIFO status logic.
REQ-011 fifo_wr_en  output  1  FIFO write strobe.
REQ-012 fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id  output  ID_WIDTH  index of the currently granted requester.
REQ-014 busy  output  1  high when state is GRANT.

Function
REQ-015 Transfer on requester i shall occur in a cycle iff req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready[i] shall be combinational: high iff state is GRANT, grant_id == i, and fifo_full is low.
REQ-017 fifo_wr_en shall equal the OR of all transfers; fifo_wr_data shall equal req_data of grant_id, combinationally (zero latency).
REQ-018 State machine: two states, IDLE and GRANT.
REQ-019 IDLE: if any req_valid is high, the scheduler shall select a winner round-robin, starting at (last_grant+1) mod NUM_REQ and searching upward with wrap, register it into grant_id and last_grant, and enter GRANT next cycle; otherwise it shall remain in IDLE.
REQ-020 GRANT: on the releasing transfer (see REQ-028/029), the scheduler shall return to IDLE; arbitration for the next grant therefore costs exactly one idle cycle.
REQ-021 While in GRANT with fifo_full high, req_ready shall be low, no write shall occur, and the grant shall be held.
REQ-022 While in GRANT with the granted req_valid low, the grant shall be held; valid shall not be required to stay high between beats.
REQ-023 Requesters shall hold req_valid, req_data and req_last stable until the transfer completes.
REQ-024 Non-granted requesters shall never see req_ready high.
REQ-025 fifo_full rising in the same cycle as a valid beat shall block that beat (no write while full).

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), busy=0; req_ready=0 and fifo_wr_en=0 follow combinationally.
REQ-027 Reset asserted mid-packet shall abort the grant with no further writes; after release, arbitration restarts from requester 0.

Configuration
REQ-028 Macro FIFO_SCHED_PKT_LOCK_EN defined: the grant shall be held across beats until a transfer with req_last high of the granted requester; that transfer releases the grant.
REQ-029 Macro FIFO_SCHED_PKT_LOCK_EN undefined: every transfer shall release the grant (one beat per grant), and req_last shall be ignored.

Verification
REQ-030 Reset then req_valid=4'b1111 held -> grants 0,1,2,3,0 in order, each write one cycle after its grant, one idle cycle between grants.
REQ-031 With lock: req 2 sends 3 beats (0xA1,0xA2,0xA3, last on 0xA3) while req 0 valid -> fifo_wr_data A1,A2,A3 on consecutive cycles, then grant moves to 3->0 search, giving 0.
REQ-032 fifo_full high for 5 cycles during a granted burst -> fifo_wr_en=0 and req_ready=0 for those 5 cycles, grant_id unchanged, burst resumes on the next cycle.
REQ-033 Without lock: req 1 and req 3 valid with 2 beats each -> write order 1,3,1,3.
REQ-034 rst_n pulsed low mid-burst of req 2 -> fifo_wr_en low immediately; after release with req 0 and req 2 valid -> req 0 granted first.
REQ-035 Only req 1 valid, single beat, repeatedly -> write every second cycle; grant_id=1 each time; busy toggles 0/1.

Source files
------------

// File: rtl/fifo_wr_sched.sv
// fifo_wr_sched: round-robin write scheduler feeding a single FIFO write port.
// NUM_REQ requesters compete for the FIFO. An IDLE cycle picks a winner
// round-robin. The winner then owns the port in GRANT until its releasing
// transfer.
// Optional build macro FIFO_SCHED_PKT_LOCK_EN:
//   defined   -> the grant is held until the beat with req_last high (packet lock)
//   undefined -> every accepted beat releases the grant, and req_last is ignored

// Per-requester handshake slice: ready/transfer for one lane.
module fifo_wr_sched_lane (
  input  logic grant_hit,  // grant_id points at this lane
  input  logic port_open,  // scheduler in GRANT and FIFO not full
  input  logic valid,
  output logic ready,
  output logic xfer
);

  assign ready = grant_hit & port_open;
  assign xfer  = ready & valid;

endmodule

module fifo_wr_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  // Width needed to index one requester lane.
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
  logic [NUM_REQ-1:0]                 xfer;
  logic                               port_open;
  logic                               release_grant;
  logic [IW-1:0]                      gsel;
  logic [IW-1:0]                      cand;
  logic [IW-1:0]                      win_idx;
  logic                               win_found;

  assign req_data_a = req_data;
  assign gsel       = IW'(grant_id_q);
  assign port_open  = (state_q == S_GRANT) && !fifo_full;

  // One handshake slice per requester. Only the granted lane can ever be ready.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    fifo_wr_sched_lane u_lane (
      .grant_hit (grant_id_q == ID_WIDTH'(g)),
      .port_open (port_open),
      .valid     (req_valid[g]),
      .ready     (req_ready[g]),
      .xfer      (xfer[g])
    );
  end

  // Decide whether this cycle's transfer ends the grant.
`ifdef FIFO_SCHED_PKT_LOCK_EN
  assign release_grant = |(xfer & req_last);
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign release_grant   = |xfer;
`endif

  // Round-robin search. It starts one past the last winner and wraps upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, and hold the grant until the release.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_GRANT;
          grant_id_d   = ID_WIDTH'(win_idx);
          last_grant_d = ID_WIDTH'(win_idx);
        end
      end
      S_GRANT: begin
        if (release_grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register. Reset makes requester 0 the first in round-robin order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // The write path is fully combinational: the granted beat goes straight to the FIFO.
  assign fifo_wr_en   = |xfer;
  assign fifo_wr_data = req_data_a[gsel];
  assign grant_id     = grant_id_q;
  assign busy         = (state_q == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: a vector table, directed corner sequences, and
// randomized traffic checked against a behavioural round-robin model.
module tb_fifo_wr_sched;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef FIFO_SCHED_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_wr_en, busy;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;

  int checks = 0;
  int fails  = 0;

  fifo_wr_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       full;
    logic [3:0] e_rdy;
    logic       e_wr;
    logic [7:0] e_data;
    logic [1:0] e_gid;
    logic       e_busy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    edge_();
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    edge_();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[10];
    logic [7:0] got[$];
    logic [7:0] exp_ord[4];
    int         left[N];
    bit         m_busy;
    int         m_gid, m_last;
    logic [3:0] e_rdy, xf;
    logic       e_wr;

    // All four requesters valid from reset: the grant goes 0,1,2,3,0 with an idle cycle between grants.
    tbl[0] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1] = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 8'h00, 2'd0, 1'b1};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 8'h22, 2'd2, 1'b1};
    tbl[6] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 8'h22, 2'd2, 1'b0};
    tbl[7] = '{4'hF, 4'hF, 1'b0, 4'h8, 1'b1, 8'h33, 2'd3, 1'b1};
    tbl[8] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 8'h33, 2'd3, 1'b0};
    tbl[9] = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 8'h00, 2'd0, 1'b1};

    do_reset();
    req_data = 32'h33221100;
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v; req_last = tbl[i].l; fifo_full = tbl[i].full;
      mid();
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_wr_en", i), fifo_wr_en, tbl[i].e_wr);
      chk($sformatf("tbl%0d_data", i), fifo_wr_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].e_gid);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      edge_();
    end

    // FIFO full for 5 cycles while requester 2 is granted. Full rises in the same cycle as the beat.
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0100; req_data = 32'h00B10000;
    mid();
    chk("full_pre_busy", busy, 0);
    edge_();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("full%0d_wr_en", c), fifo_wr_en, 0);
      chk($sformatf("full%0d_ready", c), req_ready, 0);
      chk($sformatf("full%0d_gid", c), grant_id, 2);
      chk($sformatf("full%0d_busy", c), busy, 1);
      edge_();
    end
    fifo_full = 1'b0;
    mid();
    chk("full_resume_wr_en", fifo_wr_en, 1);
    chk("full_resume_ready", req_ready, 4'b0100);
    chk("full_resume_data", fifo_wr_data, 8'hB1);
    edge_();

    // Requesters 1 and 3 each send 2 beats.
    do_reset();
    left[0] = 0; left[1] = 2; left[2] = 0; left[3] = 2;
    req_valid = 4'b1010; req_last = 4'b0000; req_data = 32'h30001000;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      int g;
      bit w;
      mid();
      w = fifo_wr_en;
      g = int'(grant_id);
      if (w) got.push_back(fifo_wr_data);
      edge_();
      if (w) begin
        left[g]--;
        if (left[g] == 0) req_valid[g] = 1'b0;
        else begin
          req_data[g*DW +: DW] = req_data[g*DW +: DW] + 8'h01;
          req_last[g] = (left[g] == 1);
        end
      end
    end
    if (LOCK) begin
      exp_ord[0] = 8'h10; exp_ord[1] = 8'h11; exp_ord[2] = 8'h30; exp_ord[3] = 8'h31;
    end else begin
      exp_ord[0] = 8'h10; exp_ord[1] = 8'h30; exp_ord[2] = 8'h11; exp_ord[3] = 8'h31;
    end
    chk("order_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("order%0d", k), (k < got.size()) ? got[k] : 8'hXX, exp_ord[k]);

    // Reset in the middle of requester 2's burst; then requester 0 wins over requester 2.
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000; req_data = 32'h00C200C0;
    mid();
    chk("rstmid_idle_busy", busy, 0);
    edge_();
    chk("rstmid_pre_wr_en", fifo_wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", fifo_wr_en, 0);
    chk("rstmid_ready", req_ready, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_gid", grant_id, 0);
    req_valid = 4'b0101;
    edge_();
    rst_n = 1'b1;
    mid();
    chk("rstmid_rel_busy", busy, 0);
    edge_();
    chk("rstmid_first_gid", grant_id, 0);
    chk("rstmid_first_wr", fifo_wr_en, 1);
    chk("rstmid_first_data", fifo_wr_data, 8'hC0);

    // Only requester 1 is active, with single-beat packets: a write every second cycle.
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h00005D00;
    for (int c = 0; c < 8; c++) begin
      mid();
      chk($sformatf("solo%0d_wr_en", c), fifo_wr_en, c % 2);
      chk($sformatf("solo%0d_busy", c), busy, c % 2);
      if (c % 2 == 1) chk($sformatf("solo%0d_gid", c), grant_id, 1);
      edge_();
    end

`ifdef FIFO_SCHED_PKT_LOCK_EN
    // Packet lock: requester 2 sends 3 beats while requester 0 waits.
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000; req_data = 32'h00A10000;
    mid();
    chk("lock_idle_busy", busy, 0);
    edge_();
    req_valid = 4'b0101; req_data[7:0] = 8'h55;
    for (int b = 0; b < 3; b++) begin
      mid();
      chk($sformatf("lock%0d_wr_en", b), fifo_wr_en, 1);
      chk($sformatf("lock%0d_data", b), fifo_wr_data, 8'hA1 + b);
      chk($sformatf("lock%0d_gid", b), grant_id, 2);
      edge_();
      if (b == 2) req_valid[2] = 1'b0;
      else begin
        req_data[23:16] = 8'hA2 + b;
        req_last[2] = (b == 1);
      end
    end
    mid();
    chk("lock_gap_busy", busy, 0);
    chk("lock_gap_wr_en", fifo_wr_en, 0);
    edge_();
    mid();
    chk("lock_next_gid", grant_id, 0);
    chk("lock_next_data", fifo_wr_data, 8'h55);
    edge_();
`endif

    // Randomized traffic against the behavioural model.
    do_reset();
    m_busy = 1'b0; m_gid = 0; m_last = N - 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      mid();
      for (int i = 0; i < N; i++) e_rdy[i] = m_busy && (m_gid == i) && !fifo_full;
      xf   = e_rdy & req_valid;
      e_wr = |xf;
      chk("rnd_ready", req_ready, e_rdy);
      chk("rnd_wr_en", fifo_wr_en, e_wr);
      chk("rnd_data", fifo_wr_data, req_data[m_gid*DW +: DW]);
      chk("rnd_gid", grant_id, m_gid);
      chk("rnd_busy", busy, m_busy);
      @(posedge clk);
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!m_busy && req_valid[c]) begin
            m_busy = 1'b1; m_gid = c; m_last = c;
          end
        end
      end else if (e_wr) begin
        if (!LOCK || req_last[m_gid]) m_busy = 1'b0;
      end
      #1;
      fifo_full = ($urandom_range(4, 0) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && xf[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            req_data[i*DW +: DW] = DW'($urandom);
            req_last[i] = 1'($urandom_range(1, 0));
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if (!req_valid[i] && $urandom_range(9, 0) < 4) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
          req_last[i] = 1'($urandom_range(1, 0));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
